onehot_to_bin_encoder: RTL and testbench
========================================

// Module: onehot_to_bin_encoder
// PURPOSE
//  Registered one-hot to binary encoder: inverse of the binary-to-one-hot decoder.
//  Accepts one-hot words over a valid/ready handshake and returns the binary index
//  one cycle later, flagging malformed words (zero or multiple bits set).
//  Keeps a saturating count of malformed words. Sits at the consumer end of any
//  one-hot select bus feeding binary-indexed logic.
// PARAMETERS
//  OH_W    8                 width of one-hot input; >= 2
//  BIN_W   $clog2(OH_W)      width of binary output (derived, do not override)
//  CNT_W   8                 width of malformed-word counter
// PORTS
//  clk          in   1       clock, all logic rising-edge
//  rst_n        in   1       synchronous reset, active-low
//  in_valid     in   1       input word valid
//  in_ready     out  1       encoder can accept input this cycle
//  in_onehot    in   OH_W    one-hot input word
//  out_valid    out  1       output register holds a result
//  out_ready    in   1       downstream accepts result this cycle
//  out_bin      out  BIN_W   encoded binary index
//  out_err      out  1       result came from a malformed word
//  err_count    out  CNT_W   saturating count of accepted malformed words
//  err_clr      in   1       clear err_count
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): out_valid=0, out_bin=0, out_err=0, err_count=0.
//   in_ready=0 while rst_n=0.
//  Handshake: in_ready = rst_n & (!out_valid | out_ready), combinational.
//   Accept = in_valid & in_ready. Transfer out = out_valid & out_ready.
//  Single output register, latency 1: word accepted on edge N is on out_* after N.
//  On accept: out_valid<=1.
//   - exactly one bit k set: out_bin<=k, out_err<=0.
//   - zero bits set: out_bin<=0, out_err<=1.
//   - >1 bits set: out_bin<=index of lowest set bit, out_err<=1.
//  Transfer out without accept: out_valid<=0, out_bin/out_err hold last value.
//  Transfer out with accept on the same cycle: new result loaded, out_valid stays 1
//   (full throughput, one word per cycle).
//  Stall (out_valid & !out_ready): out_bin, out_err, out_valid held stable;
//   in_ready=0; in_onehot ignored.
//  err_count: +1 on each accept of a malformed word; saturates at 2^CNT_W-1.
//   err_clr has priority: clear and malformed accept on the same edge -> 0.
//   err_clr is independent of the handshake.
//  Reset mid-stall discards the held result (out_valid=0 next cycle).
//  No X propagation: an X on in_onehot while in_valid=0 has no effect.
// TESTING
//  1 Sweep k=0..7: in_onehot=1<<k, out_ready=1 -> out_bin=k one cycle later,
//    out_err=0, back-to-back words give out_valid=1 continuously, err_count=0.
//  2 in_onehot=8'h00 then 8'h0C -> out_bin=0,out_err=1 then out_bin=2,out_err=1;
//    err_count=2.
//  3 Stall: send 8'h10, hold out_ready=0 for 3 cycles -> out_bin=4 stable,
//    in_ready=0; raise out_ready -> transfer, in_ready=1 same cycle.
//  4 Saturation: 260 malformed words (8'hFF) -> err_count=255; assert err_clr
//    together with a further 8'hFF accept -> err_count=0.
//  5 Reset mid-stall: hold result 3 with out_ready=0, drop rst_n one edge ->
//    out_valid=0, out_bin=0, err_count=0, in_ready=1 after release.
//  6 Round trip: drive bin-to-one-hot decoder with 0..7, feed into this block ->
//    out_bin equals original value, out_err=0 for all 8.

Source files
------------

// File: rtl/onehot_to_bin_encoder.sv
// Registered one-hot to binary encoder with valid/ready handshake.
// Flags malformed words (none or several bits set) and keeps a saturating error count.
module onehot_to_bin_encoder #(
    parameter int unsigned OH_W  = 8,
    parameter int unsigned BIN_W = $clog2(OH_W),
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OH_W-1:0]  in_onehot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BIN_W-1:0] out_bin,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count,
    input  logic             err_clr
);

    logic             out_valid_q, out_valid_d;
    logic [BIN_W-1:0] out_bin_q, out_bin_d;
    logic             out_err_q, out_err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic [BIN_W-1:0] lowest_idx;
    logic             found;
    logic             zero_set;
    logic             multi_set;
    logic             malformed;
    logic             accept;
    logic             xfer;

    // Priority scan from bit 0 so multi-bit words report their lowest set bit.
    always_comb begin
        lowest_idx = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < OH_W; i++) begin
            if (in_onehot[i] && !found) begin
                lowest_idx = BIN_W'(i);
                found      = 1'b1;
            end
        end
    end

    assign zero_set  = ~|in_onehot;
    assign multi_set = |(in_onehot & (in_onehot - OH_W'(1)));
    assign malformed = zero_set | multi_set;

    assign in_ready = rst_n & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign xfer     = out_valid_q & out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_bin_d   = out_bin_q;
        out_err_d   = out_err_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_bin_d   = lowest_idx;
            out_err_d   = malformed;
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    // Clear wins over a same-cycle malformed accept.
    always_comb begin
        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = '0;
        end else if (accept && malformed && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_bin_q   <= out_bin_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bin   = out_bin_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_onehot_to_bin_encoder.sv
// Directed bench for onehot_to_bin_encoder with a queue-based scoreboard.
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
module tb_onehot_to_bin_encoder;

    localparam int unsigned OH_W  = 8;
    localparam int unsigned BIN_W = 3;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [OH_W-1:0]  in_onehot;
    logic             out_valid;
    logic             out_ready;
    logic [BIN_W-1:0] out_bin;
    logic             out_err;
    logic [CNT_W-1:0] err_count;
    logic             err_clr;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] exp_q[$];
    logic       m_valid = 1'b0;
    int         m_cnt   = 0;

    onehot_to_bin_encoder #(
        .OH_W (OH_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_onehot(in_onehot),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bin  (out_bin),
        .out_err  (out_err),
        .err_count(err_count),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference result {err, bin}: lowest set bit, error unless exactly one bit is set.
    function automatic logic [3:0] ref_enc(input logic [7:0] w);
        logic [2:0] b;
        b = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w[i]) b = 3'(i);
        end
        return {($countones(w) != 1), b};
    endfunction

    always @(negedge clk) begin
        logic exp_ready;
        logic acc;
        logic [3:0] r;
        exp_ready = rst_n & (~m_valid | out_ready);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("err_count", 32'(err_count), 32'(m_cnt));
        acc = in_valid & exp_ready;
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'(1), 32'(0));
            end else begin
                check("out_bin", 32'(out_bin), 32'(exp_q[0][2:0]));
                check("out_err", 32'(out_err), 32'(exp_q[0][3]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        if (!rst_n) begin
            m_valid = 1'b0;
            m_cnt   = 0;
            exp_q.delete();
        end else begin
            if (acc) begin
                r = ref_enc(in_onehot);
                exp_q.push_back(r);
                m_valid = 1'b1;
                if (r[3] && m_cnt < 255) m_cnt++;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (err_clr) m_cnt = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_onehot = 'x;
    endtask

    initial begin
        logic [7:0] dec;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_onehot = 'x;
        out_ready = 1'b1;
        err_clr   = 1'b0;

        // Reset state
        step();
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_bin", 32'(out_bin), 32'(0));
        check("rst_out_err", 32'(out_err), 32'(0));
        check("rst_err_count", 32'(err_count), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(0));
        step();
        rst_n = 1'b1;

        // 1: sweep of all one-hot positions, back to back
        for (int k = 0; k < 8; k++) begin
            step();
            in_valid  = 1'b1;
            in_onehot = 8'(1) << k;
        end
        step();
        idle();
        step();
        step();
        check("sweep_err_count", 32'(err_count), 32'(0));

        // 2: zero word and multi-bit word
        step();
        in_valid  = 1'b1;
        in_onehot = 8'h00;
        step();
        in_onehot = 8'h0C;
        step();
        idle();
        step();
        step();
        check("malformed_err_count", 32'(err_count), 32'(2));

        // 3: stall for three cycles, input changes must be ignored
        step();
        in_valid  = 1'b1;
        in_onehot = 8'h10;
        out_ready = 1'b0;
        step();
        in_valid  = 1'b0;
        in_onehot = 8'h01;
        for (int i = 0; i < 3; i++) begin
            check("stall_out_bin", 32'(out_bin), 32'(4));
            check("stall_in_ready", 32'(in_ready), 32'(0));
            step();
        end
        out_ready = 1'b1;
        #1;
        check("unstall_in_ready", 32'(in_ready), 32'(1));
        step();
        idle();
        step();

        // 4: saturation, then clear together with a malformed accept
        in_valid  = 1'b1;
        in_onehot = 8'hFF;
        for (int i = 0; i < 260; i++) step();
        check("sat_err_count", 32'(err_count), 32'(255));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        idle();
        check("clr_err_count", 32'(err_count), 32'(0));
        step();

        // 5: reset while a result is stalled
        in_valid  = 1'b1;
        in_onehot = 8'h08;
        out_ready = 1'b0;
        step();
        idle();
        step();
        check("held_out_bin", 32'(out_bin), 32'(3));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rststall_out_valid", 32'(out_valid), 32'(0));
        check("rststall_out_bin", 32'(out_bin), 32'(0));
        check("rststall_err_count", 32'(err_count), 32'(0));
        #1;
        check("rststall_in_ready", 32'(in_ready), 32'(1));
        out_ready = 1'b1;
        step();

        // 6: round trip through a binary-to-one-hot decoder
        for (int v = 0; v < 8; v++) begin
            dec       = 8'(1) << v;
            in_valid  = 1'b1;
            in_onehot = dec;
            step();
        end
        idle();
        for (int i = 0; i < 4; i++) step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
